// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP word, default boot PC.
// The optional performance counters are enabled by defining FETCH_PERF_EN.
package fetch_redirect_unit_pkg;

    localparam logic [31:0] RISCV_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT    = 2'd0,
        FETCH_RUN     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_perf_counters.sv
// Redirect / dropped-response event counters for the fetch stage.
// Only built when FETCH_PERF_EN is defined; both counters wrap at 2^PERF_W.
`ifdef FETCH_PERF_EN
module fetch_perf_counters #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic              discard,
    output logic [PERF_W-1:0] perf_redirects,
    output logic [PERF_W-1:0] perf_discards
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects <= '0;
            perf_discards  <= '0;
        end else begin
            if (redirect) perf_redirects <= perf_redirects + PERF_W'(1);
            if (discard)  perf_discards  <= perf_discards + PERF_W'(1);
        end
    end

endmodule
`endif

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC sequencer: one outstanding imem request, redirect/flush handling, stall skid.
// Define FETCH_PERF_EN to instantiate fetch_perf_counters; otherwise perf outputs are tied to 0.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              x_pc_select,
    input  logic [31:0]       x_target,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              f_valid,
    output logic [31:0]       f_instr,
    output logic [31:0]       f_pc,
    output logic              fd_flush,
    output logic              dx_flush,
    output logic              fetch_misalign,
    output logic [PERF_W-1:0] perf_redirects,
    output logic [PERF_W-1:0] perf_discards,
    output fetch_state_e      fsm_state
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         outstanding_q;
    logic         skid_valid_q;
    logic [31:0]  skid_instr_q;
    logic [31:0]  skid_pc_q;
    logic         run;
    logic         accept;

    // Handshake: a request transfers on any cycle where imem_req && imem_ready;
    // imem_req never depends on imem_ready, and responses return in order.
    assign run       = (state_q == FETCH_RUN);
    assign imem_req  = run && (!outstanding_q || imem_rvalid) && !stall && !(f_valid && stall)
                       && !skid_valid_q && !x_pc_select;
    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc_q;
    assign fd_flush  = x_pc_select;
    assign dx_flush  = x_pc_select;
    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FETCH_BOOT;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            outstanding_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_instr_q   <= RISCV_NOP;
            skid_pc_q      <= '0;
            f_valid        <= 1'b0;
            f_instr        <= RISCV_NOP;
            f_pc           <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= x_pc_select && (|x_target[1:0]);

            if (accept) begin
                pc_q          <= pc_q + 32'd4;
                req_pc_q      <= pc_q;
                outstanding_q <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding_q <= 1'b0;
            end

            if (x_pc_select) begin
                // A response landing in the redirect cycle itself is simply dropped here.
                pc_q         <= align_word(x_target);
                f_valid      <= 1'b0;
                skid_valid_q <= 1'b0;
                state_q      <= (outstanding_q && !imem_rvalid) ? FETCH_DISCARD : FETCH_RUN;
            end else begin
                case (state_q)
                    FETCH_BOOT:    state_q <= FETCH_RUN;
                    FETCH_DISCARD: if (imem_rvalid) state_q <= FETCH_RUN;
                    default:       ;
                endcase

                if (!stall) begin
                    if (run && imem_rvalid) begin
                        f_valid <= 1'b1;
                        f_instr <= imem_rdata;
                        f_pc    <= req_pc_q;
                    end else if (skid_valid_q) begin
                        f_valid      <= 1'b1;
                        f_instr      <= skid_instr_q;
                        f_pc         <= skid_pc_q;
                        skid_valid_q <= 1'b0;
                    end else begin
                        f_valid <= 1'b0;
                    end
                end else if (run && imem_rvalid) begin
                    skid_valid_q <= 1'b1;
                    skid_instr_q <= imem_rdata;
                    skid_pc_q    <= req_pc_q;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic discard_event;
    assign discard_event = ((state_q == FETCH_DISCARD) && imem_rvalid) || (x_pc_select && skid_valid_q);

    fetch_perf_counters #(.PERF_W(PERF_W)) u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (x_pc_select),
        .discard        (discard_event),
        .perf_redirects (perf_redirects),
        .perf_discards  (perf_discards)
    );
`else
    assign perf_redirects = '0;
    assign perf_discards  = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a configurable-latency instruction memory.
// Expected perf counts depend on whether FETCH_PERF_EN is defined.
module tb_fetch_redirect_unit;
    import fetch_redirect_unit_pkg::*;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         x_pc_select;
    logic [31:0]  x_target;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         f_valid;
    logic [31:0]  f_instr;
    logic [31:0]  f_pc;
    logic         fd_flush;
    logic         dx_flush;
    logic         fetch_misalign;
    logic [31:0]  perf_redirects;
    logic [31:0]  perf_discards;
    fetch_state_e fsm_state;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 1;

    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .x_pc_select    (x_pc_select),
        .x_target       (x_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .f_valid        (f_valid),
        .f_instr        (f_instr),
        .f_pc           (f_pc),
        .fd_flush       (fd_flush),
        .dx_flush       (dx_flush),
        .fetch_misalign (fetch_misalign),
        .perf_redirects (perf_redirects),
        .perf_discards  (perf_discards),
        .fsm_state      (fsm_state)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Memory model: lat=1 answers in the cycle right after the accepting edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            pend        <= 1'b0;
            pend_addr   <= '0;
            cnt         <= 0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= word(pend_addr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req && imem_ready) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= word(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    cnt       <= lat - 2;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; x_pc_select = 1'b0; x_target = '0; imem_ready = 1'b1;
        tick; tick;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_fvalid", 32'(f_valid), 32'd0);
        chk("rst_finstr", f_instr, RISCV_NOP);
        chk("rst_fpc", f_pc, 32'h0);
        chk("rst_state", 32'(fsm_state), 32'(FETCH_BOOT));
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
        chk("rst_perf_r", perf_redirects, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 32'd0);
        chk("boot_flush", 32'(fd_flush), 32'd0);

        // Sequential fetch, 1-cycle memory
        tick; chk("c1_state", 32'(fsm_state), 32'(FETCH_RUN));
        chk("c1_req", 32'(imem_req), 32'd1); chk("c1_addr", imem_addr, 32'h0);
        tick; chk("c2_addr", imem_addr, 32'h4); chk("c2_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c3_fvalid", 32'(f_valid), 32'd1); chk("c3_fpc", f_pc, 32'h0);
        chk("c3_finstr", f_instr, word(32'h0)); chk("c3_addr", imem_addr, 32'h8);
        tick; chk("c4_fpc", f_pc, 32'h4); chk("c4_finstr", f_instr, word(32'h4));
        chk("c4_addr", imem_addr, 32'hC);
        lat = 2;

        // Redirect with a request in flight and no response yet
        tick; chk("c5_req_wait", 32'(imem_req), 32'd0); chk("c5_fpc", f_pc, 32'h8);
        x_pc_select = 1'b1; x_target = 32'h100; #1;
        chk("c5_fd_flush", 32'(fd_flush), 32'd1); chk("c5_dx_flush", 32'(dx_flush), 32'd1);
        chk("c5_req_redir", 32'(imem_req), 32'd0);
        tick; x_pc_select = 1'b0; lat = 1; #1;
        chk("c6_flush", 32'(fd_flush), 32'd0); chk("c6_state", 32'(fsm_state), 32'(FETCH_DISCARD));
        chk("c6_req", 32'(imem_req), 32'd0); chk("c6_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c7_state", 32'(fsm_state), 32'(FETCH_RUN)); chk("c7_addr", imem_addr, 32'h100);
        chk("c7_req", 32'(imem_req), 32'd1); chk("c7_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c8_addr", imem_addr, 32'h104); chk("c8_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c9_fvalid", 32'(f_valid), 32'd1); chk("c9_fpc", f_pc, 32'h100);
        chk("c9_finstr", f_instr, word(32'h100));

        // Misaligned redirect target
        x_pc_select = 1'b1; x_target = 32'h102; #1;
        chk("c9_flush", 32'(dx_flush), 32'd1); chk("c9_req", 32'(imem_req), 32'd0);
        chk("c9_misalign", 32'(fetch_misalign), 32'd0);
        tick; x_pc_select = 1'b0; #1;
        chk("c10_misalign", 32'(fetch_misalign), 32'd1); chk("c10_addr", imem_addr, 32'h100);
        chk("c10_fvalid", 32'(f_valid), 32'd0); chk("c10_state", 32'(fsm_state), 32'(FETCH_RUN));
        tick; chk("c11_misalign", 32'(fetch_misalign), 32'd0); chk("c11_addr", imem_addr, 32'h104);
        chk("c11_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c12_fvalid", 32'(f_valid), 32'd1); chk("c12_fpc", f_pc, 32'h100);
        chk("c12_finstr", f_instr, word(32'h100));

        // Stall for 3 cycles with a response in flight
        stall = 1'b1; #1; chk("c12_req_stall", 32'(imem_req), 32'd0);
        tick; chk("c13_fpc", f_pc, 32'h100); chk("c13_fvalid", 32'(f_valid), 32'd1);
        chk("c13_req", 32'(imem_req), 32'd0);
        tick; chk("c14_fpc", f_pc, 32'h100); chk("c14_finstr", f_instr, word(32'h100));
        tick; stall = 1'b0; #1;
        chk("c15_req_skid", 32'(imem_req), 32'd0); chk("c15_fpc", f_pc, 32'h100);
        tick; chk("c16_fvalid", 32'(f_valid), 32'd1); chk("c16_fpc", f_pc, 32'h104);
        chk("c16_finstr", f_instr, word(32'h104)); chk("c16_addr", imem_addr, 32'h108);
        chk("c16_req", 32'(imem_req), 32'd1);
        tick; chk("c17_fvalid", 32'(f_valid), 32'd0); chk("c17_addr", imem_addr, 32'h10C);
        tick; chk("c18_fpc", f_pc, 32'h108); chk("c18_finstr", f_instr, word(32'h108));
        chk("c18_addr", imem_addr, 32'h110);

        // Memory not ready for 4 cycles
        imem_ready = 1'b0;
        tick; chk("c19_fpc", f_pc, 32'h10C); chk("c19_addr", imem_addr, 32'h110);
        chk("c19_req", 32'(imem_req), 32'd1);
        tick; chk("c20_fvalid", 32'(f_valid), 32'd0); chk("c20_addr", imem_addr, 32'h110);
        tick; chk("c21_fvalid", 32'(f_valid), 32'd0); chk("c21_addr", imem_addr, 32'h110);
        tick; imem_ready = 1'b1; #1;
        chk("c22_addr", imem_addr, 32'h110); chk("c22_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c23_addr", imem_addr, 32'h114); chk("c23_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c24_fpc", f_pc, 32'h110); chk("c24_finstr", f_instr, word(32'h110));
        chk("c24_addr", imem_addr, 32'h118);
        chk("c24_perf_r", perf_redirects, PERF ? 32'd2 : 32'd0);
        chk("c24_perf_d", perf_discards, PERF ? 32'd1 : 32'd0);

        // Redirect while stalled with the skid buffer occupied
        stall = 1'b1;
        tick; chk("c25_fpc", f_pc, 32'h110);
        x_pc_select = 1'b1; x_target = 32'h300; #1;
        chk("c25_flush", 32'(fd_flush), 32'd1); chk("c25_req", 32'(imem_req), 32'd0);
        tick; x_pc_select = 1'b0; stall = 1'b0; #1;
        chk("c26_req", 32'(imem_req), 32'd1); chk("c26_addr", imem_addr, 32'h300);
        chk("c26_fvalid", 32'(f_valid), 32'd0);
        chk("c26_perf_r", perf_redirects, PERF ? 32'd3 : 32'd0);
        chk("c26_perf_d", perf_discards, PERF ? 32'd2 : 32'd0);
        tick; chk("c27_addr", imem_addr, 32'h304); chk("c27_fvalid", 32'(f_valid), 32'd0);
        tick; chk("c28_fpc", f_pc, 32'h300); chk("c28_finstr", f_instr, word(32'h300));
        chk("c28_fvalid", 32'(f_valid), 32'd1);

        // Reset mid-request, then redirect during BOOT to the top of the address space
        rst_n = 1'b0; #1;
        chk("rr_fvalid", 32'(f_valid), 32'd0); chk("rr_req", 32'(imem_req), 32'd0);
        chk("rr_finstr", f_instr, RISCV_NOP); chk("rr_state", 32'(fsm_state), 32'(FETCH_BOOT));
        chk("rr_perf_r", perf_redirects, 32'd0); chk("rr_perf_d", perf_discards, 32'd0);
        x_pc_select = 1'b1; x_target = 32'hFFFF_FFFC;
        tick; rst_n = 1'b1; #1;
        chk("b0_state", 32'(fsm_state), 32'(FETCH_BOOT)); chk("b0_req", 32'(imem_req), 32'd0);
        chk("b0_flush", 32'(fd_flush), 32'd1);
        tick; x_pc_select = 1'b0; #1;
        chk("b1_state", 32'(fsm_state), 32'(FETCH_RUN)); chk("b1_addr", imem_addr, 32'hFFFF_FFFC);
        chk("b1_req", 32'(imem_req), 32'd1);
        chk("b1_perf_r", perf_redirects, PERF ? 32'd1 : 32'd0);
        tick; chk("b2_addr_wrap", imem_addr, 32'h0);
        tick; chk("b3_fpc", f_pc, 32'hFFFF_FFFC); chk("b3_finstr", f_instr, word(32'hFFFF_FFFC));
        chk("b3_addr", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
